// File: rtl/spi_cmd_tx_if.sv
// rtl/spi_cmd_tx_if.sv - command handshake bundle for the SPI paint-command initiator

interface spi_cmd_tx_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_x;
  logic [7:0] cmd_y;
  logic       cmd_brush;
  logic [2:0] cmd_color;

  modport master (
    output cmd_valid,
    output cmd_x,
    output cmd_y,
    output cmd_brush,
    output cmd_color,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_x,
    input  cmd_y,
    input  cmd_brush,
    input  cmd_color,
    output cmd_ready
  );
endinterface

// File: rtl/spi_cmd_tx.sv
// rtl/spi_cmd_tx.sv - SPI mode-0 initiator sending one 24-bit paint command per cs frame

module spi_cmd_tx #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int IDLE_GAP = 2
) (
  input  logic         clk,
  input  logic         reset,
  spi_cmd_tx_if.slave  cmd,
  output logic         sck,
  output logic         sdo,
  output logic         cs,
  output logic         busy,
  output logic         frame_done
);

  // One down-counter serves every timed phase, so it is sized for the longest one.
  localparam int MAX_A = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int MAX_B = (CS_HOLD > IDLE_GAP) ? CS_HOLD : IDLE_GAP;
  localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW    = (MAX_P < 2) ? 1 : $clog2(MAX_P);

  localparam logic [CW-1:0] DIV_LD   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] SETUP_LD = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] HOLD_LD  = CW'(CS_HOLD - 1);
  localparam logic [CW-1:0] GAP_LD   = CW'(IDLE_GAP - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [4:0]    bit_cnt;
  logic [23:0]   shreg;
  logic [23:0]   frame;

  assign frame = {cmd.cmd_x, cmd.cmd_y, cmd.cmd_brush, cmd.cmd_color, 4'b0000};

  // Frame sequencer; every output is a register so cs/sck/sdo never glitch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      cnt           <= '0;
      bit_cnt       <= '0;
      shreg         <= '0;
      sck           <= 1'b0;
      sdo           <= 1'b0;
      cs            <= 1'b0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
      cmd.cmd_ready <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd.cmd_valid && cmd.cmd_ready) begin
            shreg         <= frame;
            sdo           <= frame[23];
            cs            <= 1'b1;
            busy          <= 1'b1;
            cmd.cmd_ready <= 1'b0;
            cnt           <= SETUP_LD;
            state         <= SETUP;
          end else begin
            cmd.cmd_ready <= 1'b1;
          end
        end

        SETUP: begin
          if (cnt == '0) begin
            cnt     <= DIV_LD;
            bit_cnt <= 5'd23;
            state   <= SHIFT;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end

        // Low half then high half per bit; sdo only advances on the falling step.
        SHIFT: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else if (!sck) begin
            sck <= 1'b1;
            cnt <= DIV_LD;
          end else begin
            sck <= 1'b0;
            if (bit_cnt == 5'd0) begin
              cnt   <= HOLD_LD;
              state <= HOLD;
            end else begin
              bit_cnt <= bit_cnt - 5'd1;
              shreg   <= shreg << 1;
              sdo     <= shreg[22];
              cnt     <= DIV_LD;
            end
          end
        end

        HOLD: begin
          if (cnt == '0) begin
            cs         <= 1'b0;
            sdo        <= 1'b0;
            frame_done <= 1'b1;
            cnt        <= GAP_LD;
            state      <= GAP;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end

        GAP: begin
          if (cnt == '0) begin
            busy          <= 1'b0;
            cmd.cmd_ready <= 1'b1;
            state         <= IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end

        default: begin
          sck           <= 1'b0;
          sdo           <= 1'b0;
          cs            <= 1'b0;
          busy          <= 1'b0;
          cmd.cmd_ready <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_cmd_tx.sv
// tb/tb_spi_cmd_tx.sv - directed self-checking bench for spi_cmd_tx with a loopback receiver model

module tb_spi_cmd_tx;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  spi_cmd_tx_if ifc0 ();
  spi_cmd_tx_if ifc1 ();

  logic sck0, sdo0, cs0, busy0, fd0;
  logic sck1, sdo1, cs1, busy1, fd1;

  spi_cmd_tx dut0 (
    .clk        (clk),
    .reset      (reset),
    .cmd        (ifc0),
    .sck        (sck0),
    .sdo        (sdo0),
    .cs         (cs0),
    .busy       (busy0),
    .frame_done (fd0)
  );

  spi_cmd_tx #(.CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1), .IDLE_GAP(1)) dut1 (
    .clk        (clk),
    .reset      (reset),
    .cmd        (ifc1),
    .sck        (sck1),
    .sdo        (sdo1),
    .cs         (cs1),
    .busy       (busy1),
    .frame_done (fd1)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Accept monitors: record the edge index of every handshake.
  int acc0 [16];
  int acc1 [16];
  int n_acc0 = 0;
  int n_acc1 = 0;
  always @(posedge clk) begin
    if (reset && ifc0.cmd_valid && ifc0.cmd_ready && n_acc0 < 16) begin
      acc0[n_acc0] = cyc;
      n_acc0++;
    end
    if (reset && ifc1.cmd_valid && ifc1.cmd_ready && n_acc1 < 16) begin
      acc1[n_acc1] = cyc;
      n_acc1++;
    end
  end

  // Loopback receiver models: sample sdo on sck rise while cs, latch word on cs fall.
  logic [23:0] rx_sh0, rx_sh1;
  int rx_n0, rx_n1;
  logic [23:0] rx_words0 [8];
  logic [23:0] rx_words1 [8];
  int rx_bits0 [8];
  int rx_bits1 [8];
  int n_rx0 = 0;
  int n_rx1 = 0;

  always @(posedge cs0) rx_n0 = 0;
  always @(posedge sck0) if (cs0) begin rx_sh0 = {rx_sh0[22:0], sdo0}; rx_n0++; end
  always @(negedge cs0) if (n_rx0 < 8) begin rx_words0[n_rx0] = rx_sh0; rx_bits0[n_rx0] = rx_n0; n_rx0++; end

  always @(posedge cs1) rx_n1 = 0;
  always @(posedge sck1) if (cs1) begin rx_sh1 = {rx_sh1[22:0], sdo1}; rx_n1++; end
  always @(negedge cs1) if (n_rx1 < 8) begin rx_words1[n_rx1] = rx_sh1; rx_bits1[n_rx1] = rx_n1; n_rx1++; end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_cmd0(input logic [7:0] x, input logic [7:0] y, input logic b, input logic [2:0] c);
    ifc0.cmd_x = x; ifc0.cmd_y = y; ifc0.cmd_brush = b; ifc0.cmd_color = c;
  endtask

  task automatic wait_acc0(input int target);
    for (int i = 0; i < 1000 && n_acc0 < target; i++) @(negedge clk);
    check("accept0_timeout", (n_acc0 >= target), 1);
  endtask

  task automatic wait_acc1(input int target);
    for (int i = 0; i < 1000 && n_acc1 < target; i++) @(negedge clk);
    check("accept1_timeout", (n_acc1 >= target), 1);
  endtask

  task automatic wait_rx0(input int target);
    for (int i = 0; i < 1000 && n_rx0 < target; i++) @(negedge clk);
    check("frame0_timeout", (n_rx0 >= target), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cs_bad, fd_bad, rdy_bad, busy_bad, sck_bad, idle_tog;
    int first_rise, last_high, base, r;

    reset = 1'b0;
    ifc0.cmd_valid = 1'b0; set_cmd0(8'h00, 8'h00, 1'b0, 3'd0);
    ifc1.cmd_valid = 1'b0; ifc1.cmd_x = 8'h00; ifc1.cmd_y = 8'h00; ifc1.cmd_brush = 1'b0; ifc1.cmd_color = 3'd0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cs", cs0, 0);
    check("rst_sck", sck0, 0);
    check("rst_sdo", sdo0, 0);
    check("rst_ready", ifc0.cmd_ready, 0);
    check("rst_busy", busy0, 0);
    check("rst_frame_done", fd0, 0);
    reset = 1'b1;
    @(negedge clk);
    check("ready_after_release", ifc0.cmd_ready, 1);
    check("ready1_after_release", ifc1.cmd_ready, 1);

    // Single command, plus a valid pulse while busy that must be ignored
    set_cmd0(8'hA5, 8'h3C, 1'b1, 3'd5);
    ifc0.cmd_valid = 1'b1;
    wait_acc0(1);
    ifc0.cmd_valid = 1'b0;
    base = n_rx0;
    cs_bad = 0; fd_bad = 0; rdy_bad = 0; busy_bad = 0; idle_tog = 0;
    first_rise = -1; last_high = -1;
    for (int k = 1; k <= 199; k++) begin
      if (k > 1) @(negedge clk);
      r = cyc - acc0[0];
      if (cs0 !== (r <= 196)) cs_bad++;
      if (fd0 !== (r == 197)) fd_bad++;
      if (ifc0.cmd_ready !== (r == 199)) rdy_bad++;
      if (busy0 !== (r <= 198)) busy_bad++;
      if (sck0 === 1'b1 && first_rise < 0) first_rise = r;
      if (sck0 === 1'b1) last_high = r;
      if (!cs0 && sck0) idle_tog++;
      if (k == 100) ifc0.cmd_valid = 1'b1;
      if (k == 101) ifc0.cmd_valid = 1'b0;
    end
    check("cs_window", cs_bad, 0);
    check("frame_done_pulse", fd_bad, 0);
    check("ready_window", rdy_bad, 0);
    check("busy_window", busy_bad, 0);
    check("first_sck_rise", first_rise, 7);
    check("last_sck_fall", last_high + 1, 195);
    check("sck_idle_toggle", idle_tog, 0);
    check("busy_pulse_ignored", n_acc0, 1);
    check("single_frames", n_rx0 - base, 1);
    check("single_word", rx_words0[n_rx0-1], 24'hA53CD0);
    check("single_bits", rx_bits0[n_rx0-1], 24);
    check("rx_x", rx_words0[n_rx0-1][23:16], 8'hA5);
    check("rx_y", rx_words0[n_rx0-1][15:8], 8'h3C);
    check("rx_brush", rx_words0[n_rx0-1][7], 1);
    check("rx_color", rx_words0[n_rx0-1][6:4], 3'd5);

    // Back-to-back with cmd_valid held high
    base = n_rx0;
    set_cmd0(8'h00, 8'h00, 1'b0, 3'd0);
    ifc0.cmd_valid = 1'b1;
    wait_acc0(2);
    set_cmd0(8'hFF, 8'hEF, 1'b1, 3'd7);
    wait_acc0(3);
    set_cmd0(8'h10, 8'h20, 1'b0, 3'd2);
    wait_acc0(4);
    ifc0.cmd_valid = 1'b0;
    wait_rx0(base + 3);
    check("b2b_period_1", acc0[2] - acc0[1], 199);
    check("b2b_period_2", acc0[3] - acc0[2], 199);
    check("b2b_word_0", rx_words0[base], 24'h000000);
    check("b2b_word_1", rx_words0[base+1], 24'hFFEFF0);
    check("b2b_word_2", rx_words0[base+2], 24'h102020);
    check("b2b_bits_1", rx_bits0[base+1], 24);
    check("b2b_bits_2", rx_bits0[base+2], 24);

    // Asynchronous reset in the middle of SHIFT
    repeat (4) @(negedge clk);
    set_cmd0(8'hFF, 8'hFF, 1'b1, 3'd7);
    ifc0.cmd_valid = 1'b1;
    wait_acc0(5);
    ifc0.cmd_valid = 1'b0;
    for (int i = 0; i < 100 && (cyc - acc0[4]) < 50; i++) @(negedge clk);
    check("pre_abort_cs", cs0, 1);
    check("pre_abort_sck", sck0, 1);
    check("pre_abort_sdo", sdo0, 1);
    #1 reset = 1'b0;
    #1;
    check("abort_cs", cs0, 0);
    check("abort_sck", sck0, 0);
    check("abort_sdo", sdo0, 0);
    check("abort_busy", busy0, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("ready_after_abort", ifc0.cmd_ready, 1);
    base = n_rx0;
    set_cmd0(8'h12, 8'h34, 1'b1, 3'd6);
    ifc0.cmd_valid = 1'b1;
    wait_acc0(6);
    ifc0.cmd_valid = 1'b0;
    wait_rx0(base + 1);
    check("post_abort_word", rx_words0[base], 24'h1234E0);
    check("post_abort_bits", rx_bits0[base], 24);

    // Minimum timing parameters on the second instance
    ifc1.cmd_x = 8'h5A; ifc1.cmd_y = 8'hC3; ifc1.cmd_brush = 1'b0; ifc1.cmd_color = 3'd3;
    ifc1.cmd_valid = 1'b1;
    wait_acc1(1);
    sck_bad = 0; cs_bad = 0;
    for (int k = 1; k <= 51; k++) begin
      if (k > 1) @(negedge clk);
      r = cyc - acc1[0];
      if (sck1 !== ((r >= 2) && (r <= 49) && (r % 2 == 1))) sck_bad++;
      if (cs1 !== ((r >= 1) && (r <= 50))) cs_bad++;
    end
    check("fast_sck_pattern", sck_bad, 0);
    check("fast_cs_window", cs_bad, 0);
    wait_acc1(2);
    ifc1.cmd_valid = 1'b0;
    check("fast_period", acc1[1] - acc1[0], 52);
    check("fast_word", rx_words1[0], 24'h5AC330);
    check("fast_bits", rx_bits1[0], 24);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_cmd_tx.md
Name: spi_cmd_tx

Overview:
- SPI initiator that serialises one paint command (x, y, brush, colour) per frame onto sck/sdo/cs.
- It is the other end of the FPGA's MCU-facing SPI command receiver.
- Used as an on-chip stimulus source and loopback driver: its sck/sdo/cs wire straight into the receiver's sck/sdi/cs.
- Frames are bit-exact with what the receiver decodes; the bench self-checks via updateConfig/x/y.

Parameters:
CLK_DIV, 4, clk cycles per sck half-period (>=1)
CS_SETUP, 2, clk cycles cs high before first sck rise phase begins (>=1)
CS_HOLD, 2, clk cycles cs held high after last sck fall (>=1)
IDLE_GAP, 2, clk cycles cs low between frames (>=1)

Ports:
clk  in  1  system clock (VGA pixel clock domain)
reset  in  1  asynchronous, active-low reset
cmd_valid  in  1  command available
cmd_ready  out  1  block can accept a command
cmd_x  in  8  pixel x
cmd_y  in  8  pixel y
cmd_brush  in  1  brush enable
cmd_color  in  3  colour code
sck  out  1  SPI clock, mode 0 (idle low)
sdo  out  1  serial data, MSB first
cs  out  1  frame enable, active-high
busy  out  1  high from accept until return to IDLE
frame_done  out  1  one-cycle pulse when cs deasserts

Behaviour:
- Reset (reset=0, async): state IDLE. Outputs cs=0, sck=0, sdo=0, cmd_ready=0, busy=0, frame_done=0. Shift register and counters cleared.
  - Assertion mid-frame aborts immediately; no partial-frame completion.
  - cmd_ready rises on the first clk edge after reset releases.
- Frame, 24 bits, MSB first: [23:16]=cmd_x, [15:8]=cmd_y, [7]=cmd_brush, [6:4]=cmd_color, [3:0]=0.
- Handshake:
  - Accept occurs on a clk edge with cmd_valid & cmd_ready.
  - Inputs are captured into the shift register on that edge.
  - cmd_ready is registered: 1 only in IDLE, and drops the cycle after accept.
  - cmd_valid while not ready is ignored; no queuing.
- States: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
  - IDLE: cs=0, sck=0, busy=0. Accept -> SETUP.
  - SETUP: cs=1, sck=0, sdo=bit23, busy=1, for CS_SETUP cycles.
  - SHIFT: per bit, sck=0 for CLK_DIV cycles, then sck=1 for CLK_DIV cycles.
    - sdo changes only on the cycle sck goes 1->0 (next bit), so it is stable across every rising edge.
    - 24 bits take 48*CLK_DIV cycles; bit counter runs 23 down to 0.
  - HOLD: sck=0, cs=1, sdo holds bit0, for CS_HOLD cycles.
  - GAP: cs=0, sdo=0, for IDLE_GAP cycles.
    - frame_done=1 on the first GAP cycle only.
    - cmd_ready=1 on the cycle after GAP ends.
- Timing at defaults (accept edge = cycle 0):
  - cs high at cycles 1–196.
  - First sck rise at cycle 7; last sck fall at cycle 195.
  - frame_done at cycle 197; cmd_ready=1 at cycle 199.
  - Frame period back-to-back: 199 cycles.
- Invariants:
  - sck never toggles while cs=0.
  - sck is exactly 0 when cs changes.
  - Exactly 24 rising sck edges per frame.
  - Glitch-free outputs: all outputs are registered.
- Counter widths are sized from the parameters; no wrap inside a frame.

Test Plan:
- Reset mid-SHIFT (at cycle 50) -> cs, sck, sdo fall to 0 asynchronously, with no clk edge required. After release, cmd_ready=1 next edge and the next frame is complete and correct.
- Single command x=0xA5, y=0x3C, brush=1, color=5 -> sdo sampled on 24 sck rises = 0xA53CD0. cs high cycles 1–196, frame_done at 197. Loopback receiver reports x=0xA5, y=0x3C, brush=1, color=5.
- cmd_valid held high with 3 commands (0x00/0x00/0/0, 0xFF/0xEF/1/7, 0x10/0x20/0/2) -> frames 0x000000, 0xFFEFF0, 0x102020. Accepts at cycles 0, 199, 398; frames never overlap.
- cmd_valid pulsed while busy (cycle 100) -> ignored; no second frame; cmd_ready stays 0 until cycle 199.
- Parameter sweep CLK_DIV=1, CS_SETUP=1, CS_HOLD=1, IDLE_GAP=1, cmd 0x5A/0xC3/0/3 -> sck alternates every cycle. Frame 0x5AC330 is captured by the receiver. Period is 1+1+48+1+1 = 52 cycles.
